delayed_fall: RTL

DELAYED_FALL -- requirements
Module: delayed_fall

---
 rtl/delayed_fall.sv | 89 ++++++++
 1 files changed

// File: rtl/delayed_fall.sv
// Fall-delay stretcher: out rises promptly on a synchronized trigger and
// drops only after a programmable run of consecutive low samples.
module delayed_fall #(
  parameter int unsigned FALL_DELAY = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  output logic out,
  output logic fell,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FALL_DELAY);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic             s1;
  logic             trig_s;
  state_t           state;
  logic [CNT_W-1:0] lo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 1'b0;
      trig_s <= 1'b0;
    end else begin
      s1     <= trigger;
      trig_s <= s1;
    end
  end

  // Outputs are updated alongside the state so they never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      lo_cnt <= '0;
      out    <= 1'b0;
      busy   <= 1'b0;
      fell   <= 1'b0;
    end else begin
      fell <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trig_s) begin
            state <= HIGH;
            out   <= 1'b1;
            busy  <= 1'b0;
          end
        end
        HIGH: begin
          if (!trig_s) begin
            state  <= HOLD;
            lo_cnt <= ONE;
            busy   <= 1'b1;
          end
        end
        HOLD: begin
          if (trig_s) begin
            state  <= HIGH;
            lo_cnt <= '0;
            busy   <= 1'b0;
          end else if (lo_cnt == LIMIT) begin
            state  <= IDLE;
            lo_cnt <= '0;
            out    <= 1'b0;
            busy   <= 1'b0;
            fell   <= 1'b1;
          end else begin
            lo_cnt <= lo_cnt + ONE;
          end
        end
        default: begin
          state  <= IDLE;
          lo_cnt <= '0;
          out    <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
